// File: rtl/ad7822_reader_if.sv
// ad7822_reader_if -- bundles the enable input, the AD7822 parallel bus pins
// and the sample/status outputs of ad7822_reader.
// master: the reader itself (drives ADC control pins and sample outputs).
// slave : the surroundings (ADC device plus the sensing blocks / controller).
interface ad7822_reader_if;
   logic       i_enable;
   logic [7:0] i_adc_data;
   logic       i_adc_eoc_n;
   logic       o_adc_convst_n;
   logic       o_adc_cs_n;
   logic       o_adc_rd_n;
   logic [7:0] o_data;
   logic       o_valid;
   logic       o_timeout;
   logic       o_busy;

   modport master (
      input  i_enable, i_adc_data, i_adc_eoc_n,
      output o_adc_convst_n, o_adc_cs_n, o_adc_rd_n,
      output o_data, o_valid, o_timeout, o_busy
   );

   modport slave (
      output i_enable, i_adc_data, i_adc_eoc_n,
      input  o_adc_convst_n, o_adc_cs_n, o_adc_rd_n,
      input  o_data, o_valid, o_timeout, o_busy
   );
endinterface

// File: rtl/ad7822_reader.sv
// ad7822_reader -- periodic sampler for an AD7822 8-bit parallel ADC.
// Every PERIOD_CYC cycles (while enabled) it pulses CONVST low, waits for the
// synchronised EOC (with a timeout), then drives CS/RD low and captures the
// bus on the edge that ends the read strobe, presenting o_data with a
// one-cycle o_valid.
// Optional build macro AD7822_AVG4_EN: average groups of four captures and
// strobe only once per group with the mean value.
module ad7822_reader #(
   parameter int CONVST_CYC  = 3,
   parameter int RD_CYC      = 3,
   parameter int PERIOD_CYC  = 100,
   parameter int TIMEOUT_CYC = 50
) (
   input logic             CLK,
   input logic             RST_N,
   ad7822_reader_if.master bus
);

   localparam int PH_MAX = (TIMEOUT_CYC > CONVST_CYC)
                         ? ((TIMEOUT_CYC > RD_CYC) ? TIMEOUT_CYC : RD_CYC)
                         : ((CONVST_CYC  > RD_CYC) ? CONVST_CYC  : RD_CYC);
   localparam int PH_W   = $clog2(PH_MAX + 1);
   localparam int CNT_W  = $clog2(PERIOD_CYC);

   typedef enum logic [1:0] {IDLE, CONVST, WAIT_EOC, READ} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [PH_W-1:0]  phase_q, phase_d;
   logic             eoc_meta_q, eoc_sync_q;
   logic             convst_n_q, cs_n_q, rd_n_q, busy_q, valid_q, timeout_q;
   logic [7:0]       data_q;
   logic [7:0]       data_d;
   logic             valid_d;
   logic             capture, timeout_hit;

   // Sample-period counter: free-runs while enabled, parked at zero otherwise.
   always_comb begin
      period_d = '0;
      if (bus.i_enable && period_q != CNT_W'(PERIOD_CYC - 1))
         period_d = period_q + 1'b1;
   end

   // Next-state logic; phase_q times the cycles spent in each timed state.
   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      capture     = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         IDLE: begin
            phase_d = '0;
            if (bus.i_enable && period_q == '0)
               state_d = CONVST;
         end
         CONVST: begin
            if (phase_q == PH_W'(CONVST_CYC - 1)) begin
               state_d = WAIT_EOC;
               phase_d = '0;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         WAIT_EOC: begin
            if (!eoc_sync_q) begin
               state_d = READ;
               phase_d = '0;
            end else if (phase_q == PH_W'(TIMEOUT_CYC - 1)) begin
               state_d     = IDLE;
               phase_d     = '0;
               timeout_hit = 1'b1;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         READ: begin
            if (phase_q == PH_W'(RD_CYC - 1)) begin
               state_d = IDLE;
               phase_d = '0;
               capture = 1'b1;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            phase_d = '0;
         end
      endcase
   end

   // State, counters, EOC synchroniser and registered ADC control pins.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= IDLE;
         period_q   <= '0;
         phase_q    <= '0;
         eoc_meta_q <= 1'b1;
         eoc_sync_q <= 1'b1;
         convst_n_q <= 1'b1;
         cs_n_q     <= 1'b1;
         rd_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         period_q   <= period_d;
         phase_q    <= phase_d;
         eoc_meta_q <= bus.i_adc_eoc_n;
         eoc_sync_q <= eoc_meta_q;
         convst_n_q <= (state_d != CONVST);
         cs_n_q     <= (state_d != READ);
         rd_n_q     <= (state_d != READ);
         busy_q     <= (state_d != IDLE);
         if (!bus.i_enable)
            timeout_q <= 1'b0;
         else if (timeout_hit)
            timeout_q <= 1'b1;
      end
   end

`ifdef AD7822_AVG4_EN
   logic [9:0] sum_q, sum_d, sum_next;
   logic [1:0] cnt4_q, cnt4_d;
   logic       emit;

   // Four-sample accumulator; the fourth capture releases the mean.
   always_comb begin
      sum_next = sum_q + {2'b00, bus.i_adc_data};
      sum_d    = sum_q;
      cnt4_d   = cnt4_q;
      emit     = 1'b0;
      if (!bus.i_enable) begin
         sum_d  = '0;
         cnt4_d = '0;
      end else if (capture) begin
         if (cnt4_q == 2'd3) begin
            emit   = 1'b1;
            sum_d  = '0;
            cnt4_d = '0;
         end else begin
            sum_d  = sum_next;
            cnt4_d = cnt4_q + 1'b1;
         end
      end
      data_d  = emit ? sum_next[9:2] : data_q;
      valid_d = emit;
   end

   // Accumulator registers.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sum_q  <= '0;
         cnt4_q <= '0;
      end else begin
         sum_q  <= sum_d;
         cnt4_q <= cnt4_d;
      end
   end
`else
   // Every capture goes straight to the output.
   always_comb begin
      data_d  = capture ? bus.i_adc_data : data_q;
      valid_d = capture;
   end
`endif

   // Output sample register and its strobe.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign bus.o_adc_convst_n = convst_n_q;
   assign bus.o_adc_cs_n     = cs_n_q;
   assign bus.o_adc_rd_n     = rd_n_q;
   assign bus.o_data         = data_q;
   assign bus.o_valid        = valid_q;
   assign bus.o_timeout      = timeout_q;
   assign bus.o_busy         = busy_q;

endmodule
